// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage and its helpers.
//   - ALUOp encodings driven by the main decoder
//   - R-type funct codes decoded by the ALU
//   - Bit positions inside the WB and M control bundles
//   - State encoding for the iterative multiplier FSM
package cpu_pkg;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;
    localparam logic [1:0] AluOpOr    = 2'b11;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;
    localparam logic [5:0] FunctMul = 6'b011000;

    localparam int unsigned WbRegWrite = 0;
    localparam int unsigned WbMemtoReg = 1;
    localparam int unsigned MMemWrite  = 0;
    localparam int unsigned MMemRead   = 1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDone = 2'b10
    } mul_state_e;

    // True when the ID/EX instruction is an R-type multiply.
    function automatic logic is_mul_op(input logic [1:0] alu_op, input logic [5:0] funct);
        return (alu_op == AluOpRtype) && (funct == FunctMul);
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   start_i          request a multiply; sampled only in StIdle
//   a_i, b_i         operands, latched when the multiply starts
//   busy_o           combinational; high while the requester must hold
//   done_o           high for the single cycle the product is final
//   product_o        low WIDTH bits of the unsigned product
// Takes WIDTH+1 busy cycles (the start cycle plus WIDTH steps), then one
// done cycle before returning to idle.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    mul_state_e      state_q;
    logic [CntW-1:0] count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mcand_q  <= a_i;
                        mplier_q <= b_i;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= StMul;
                    end
                end
                StMul: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    // Bits shifted past WIDTH only affect the discarded high half.
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LastStep) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Gated by reset so a pipeline held in reset is never told to stall.
    assign busy_o    = ~rst_i & (((state_q == StIdle) & start_i) | (state_q == StMul));
    assign done_o    = (state_q == StDone);
    assign product_o = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, ALU and the EX/MEM pipeline register.
// Build option: define MULT_EN to add the iterative multiplier (funct
// 011000); without it a multiply yields 0 in one cycle and stall_o is 0.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   WB_i, M_i             writeback / memory control from ID/EX
//   ALUSrc_i, ALUOp_i     operand-B select, ALU operation class
//   RegDst_i              1 = rd_i, 0 = rt_i as destination
//   data1_i, data2_i      rs / rt register values
//   sign_extend_i         immediate; [5:0] carries funct
//   rs_i, rt_i, rd_i      register specifiers
//   memwb_*_i             MEM/WB forwarding source
//   WB_o, M_o, rd_o       registered control and destination
//   ALUResult_o           registered ALU or multiply result
//   writeData_o           registered forwarded rt value (store data)
//   stall_o               combinational hold request to upstream stages
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       WB_i,
    input  logic [1:0]       M_i,
    input  logic             ALUSrc_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             RegDst_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [WIDTH-1:0] sign_extend_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic             memwb_RegWrite_i,
    input  logic [4:0]       memwb_rd_i,
    input  logic [WIDTH-1:0] memwb_data_i,
    output logic [1:0]       WB_o,
    output logic [1:0]       M_o,
    output logic [WIDTH-1:0] ALUResult_o,
    output logic [WIDTH-1:0] writeData_o,
    output logic [4:0]       rd_o,
    output logic             stall_o
);

    logic [1:0]       wb_q;
    logic [1:0]       m_q;
    logic [WIDTH-1:0] alu_result_q;
    logic [WIDTH-1:0] write_data_q;
    logic [4:0]       rd_q;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] ex_result;
    logic [5:0]       funct;
    logic             alu_lt;

    assign funct = sign_extend_i[5:0];

    // Forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards.
    always_comb begin
        fwd_a = data1_i;
        if (wb_q[WbRegWrite] && (rd_q != 5'd0) && (rd_q == rs_i)) begin
            fwd_a = alu_result_q;
        end else if (memwb_RegWrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_i)) begin
            fwd_a = memwb_data_i;
        end
    end

    always_comb begin
        fwd_b = data2_i;
        if (wb_q[WbRegWrite] && (rd_q != 5'd0) && (rd_q == rt_i)) begin
            fwd_b = alu_result_q;
        end else if (memwb_RegWrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rt_i)) begin
            fwd_b = memwb_data_i;
        end
    end

    assign alu_b  = ALUSrc_i ? sign_extend_i : fwd_b;
    assign alu_lt = $signed(fwd_a) < $signed(alu_b);

    always_comb begin
        alu_res = '0;
        unique case (ALUOp_i)
            AluOpAdd: alu_res = fwd_a + alu_b;
            AluOpSub: alu_res = fwd_a - alu_b;
            AluOpOr:  alu_res = fwd_a | alu_b;
            AluOpRtype: begin
                case (funct)
                    FunctAdd: alu_res = fwd_a + alu_b;
                    FunctSub: alu_res = fwd_a - alu_b;
                    FunctAnd: alu_res = fwd_a & alu_b;
                    FunctOr:  alu_res = fwd_a | alu_b;
                    FunctSlt: alu_res = {{(WIDTH-1){1'b0}}, alu_lt};
                    // Multiply (when built in) is taken from mul_iter instead.
                    default:  alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef MULT_EN
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (is_mul_op(ALUOp_i, funct)),
        .a_i       (fwd_a),
        .b_i       (alu_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign stall_o = mul_busy;
    // ID/EX is still holding the multiply while the FSM sits in done.
    assign ex_result = mul_done ? mul_product : alu_res;
`else
    assign stall_o   = 1'b0;
    assign ex_result = alu_res;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_q         <= '0;
            m_q          <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
        end else if (stall_o) begin
            // Bubble: nothing downstream may write a register or memory.
            wb_q         <= '0;
            m_q          <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
        end else begin
            wb_q         <= WB_i;
            m_q          <= M_i;
            alu_result_q <= ex_result;
            write_data_q <= fwd_b;
            rd_q         <= RegDst_i ? rd_i : rt_i;
        end
    end

    assign WB_o        = wb_q;
    assign M_o         = m_q;
    assign ALUResult_o = alu_result_q;
    assign writeData_o = write_data_q;
    assign rd_o        = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i, M_i, ALUOp_i;
    logic        ALUSrc_i, RegDst_i;
    logic [31:0] data1_i, data2_i, sign_extend_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        memwb_RegWrite_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_data_i;
    logic [1:0]  WB_o, M_o;
    logic [31:0] ALUResult_o, writeData_o;
    logic [4:0]  rd_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Reference EX/MEM contents
    logic [1:0]  exp_wb = '0, exp_m = '0;
    logic [31:0] exp_alu = '0, exp_wd = '0;
    logic [4:0]  exp_rd = '0;
`ifdef MULT_EN
    int          mcnt = 0;  // 0 idle, 1..32 stepping, 33 result cycle
    logic [31:0] mprod = '0;
`endif

    always #5 clk = ~clk;

    ex_mem_stage #(.WIDTH(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .WB_i             (WB_i),
        .M_i              (M_i),
        .ALUSrc_i         (ALUSrc_i),
        .ALUOp_i          (ALUOp_i),
        .RegDst_i         (RegDst_i),
        .data1_i          (data1_i),
        .data2_i          (data2_i),
        .sign_extend_i    (sign_extend_i),
        .rs_i             (rs_i),
        .rt_i             (rt_i),
        .rd_i             (rd_i),
        .memwb_RegWrite_i (memwb_RegWrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_data_i     (memwb_data_i),
        .WB_o             (WB_o),
        .M_o              (M_o),
        .ALUResult_o      (ALUResult_o),
        .writeData_o      (writeData_o),
        .rd_o             (rd_o),
        .stall_o          (stall_o)
    );

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (exp_wb[0] && exp_rd != 0 && exp_rd == r) return exp_alu;
        if (memwb_RegWrite_i && memwb_rd_i != 0 && memwb_rd_i == r) return memwb_data_i;
        return v;
    endfunction

    function automatic logic [31:0] op_a();
        return fwd(rs_i, data1_i);
    endfunction

    function automatic logic [31:0] op_b();
        return ALUSrc_i ? sign_extend_i : fwd(rt_i, data2_i);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd3: return a | b;
            default: begin
                case (f)
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    function automatic logic in_is_mul();
        return ALUOp_i == 2'b10 && sign_extend_i[5:0] == 6'b011000;
    endfunction

    function automatic logic model_stall();
`ifdef MULT_EN
        return !rst_i && ((mcnt == 0 && in_is_mul()) || (mcnt >= 1 && mcnt <= 32));
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of the pipeline register
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            exp_wb <= '0; exp_m <= '0; exp_alu <= '0; exp_wd <= '0; exp_rd <= '0;
`ifdef MULT_EN
            mcnt <= 0;
`endif
        end
`ifdef MULT_EN
        else if (mcnt == 0 && in_is_mul()) begin
            mprod <= op_a() * op_b();
            mcnt <= 1;
            exp_wb <= '0; exp_m <= '0; exp_alu <= '0; exp_wd <= '0; exp_rd <= '0;
        end else if (mcnt >= 1 && mcnt <= 32) begin
            mcnt <= mcnt + 1;
            exp_wb <= '0; exp_m <= '0; exp_alu <= '0; exp_wd <= '0; exp_rd <= '0;
        end else if (mcnt == 33) begin
            mcnt <= 0;
            exp_wb <= WB_i; exp_m <= M_i; exp_alu <= mprod;
            exp_wd <= fwd(rt_i, data2_i); exp_rd <= RegDst_i ? rd_i : rt_i;
        end
`endif
        else begin
            exp_wb <= WB_i; exp_m <= M_i;
            exp_alu <= ref_alu(ALUOp_i, sign_extend_i[5:0], op_a(), op_b());
            exp_wd <= fwd(rt_i, data2_i); exp_rd <= RegDst_i ? rd_i : rt_i;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (stall_o !== model_stall() || WB_o !== exp_wb || M_o !== exp_m ||
                ALUResult_o !== exp_alu || writeData_o !== exp_wd || rd_o !== exp_rd) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual stall=%b wb=%b m=%b alu=%h wd=%h rd=%0d required stall=%b wb=%b m=%b alu=%h wd=%h rd=%0d",
                         $time, stall_o, WB_o, M_o, ALUResult_o, writeData_o, rd_o,
                         model_stall(), exp_wb, exp_m, exp_alu, exp_wd, exp_rd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] wb, input logic [1:0] m, input logic alusrc,
                         input logic [1:0] aluop, input logic regdst, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        WB_i = wb; M_i = m; ALUSrc_i = alusrc; ALUOp_i = aluop; RegDst_i = regdst;
        data1_i = d1; data2_i = d2; sign_extend_i = imm; rs_i = rs; rt_i = rt; rd_i = rd;
    endtask

    task automatic memwb(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        memwb_RegWrite_i = rw; memwb_rd_i = rd; memwb_data_i = d;
    endtask

    task automatic nop();
        instr(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    // Counts stall cycles of a multiply already presented; bounded.
    task automatic run_mul(output int n);
        n = 0;
        #1;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            if (n == 5) chk("mul_bubble", {27'd0, WB_o, M_o, rd_o[0]} | {27'd0, rd_o}, 0);
            tick();
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_instr();
        logic [31:0] imm;
        logic [5:0] f;
        imm = rand_val();
        case ($urandom_range(0, 9))
            0, 1: f = 6'b100000;
            2: f = 6'b100010;
            3: f = 6'b100100;
            4: f = 6'b100101;
            5, 6: f = 6'b101010;
            7: f = 6'b011000;
            default: f = 6'($urandom);
        endcase
        imm[5:0] = f;
        instr(2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
              1'($urandom), rand_val(), rand_val(), imm, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    initial begin
        int n;
        logic hold;
        rst_i = 1'b1;
        nop();
        memwb(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_alu", ALUResult_o, 0);
        chk("reset_ctl", {21'd0, WB_o, M_o, rd_o, stall_o}, 0);
        rst_i = 1'b0;

        // add r3 = 5 + 7
        instr(2'b01, 2'b00, 0, 2'b00, 1, 5, 7, 0, 1, 2, 3);
        #1 chk("add_no_stall", {31'd0, stall_o}, 0);
        tick();
        chk("add_result", ALUResult_o, 12);
        chk("add_rd", {27'd0, rd_o}, 3);
        chk("add_wb", {30'd0, WB_o}, 1);
        // sub r4 = r3 - r2 through EX/MEM forward
        instr(2'b01, 2'b00, 0, 2'b01, 1, 32'hDEAD, 7, 0, 3, 2, 4);
        tick();
        chk("sub_fwd", ALUResult_o, 5);
        // EX/MEM vs MEM/WB both on r3
        instr(2'b01, 2'b00, 0, 2'b00, 1, 20, 3, 0, 5, 6, 3);
        tick();
        instr(2'b01, 2'b00, 0, 2'b00, 1, 999, 0, 0, 3, 0, 7);
        memwb(1, 3, 100);
        tick();
        chk("fwd_priority", ALUResult_o, 23);
        // destination r0 never forwards
        memwb(0, 0, 0);
        instr(2'b01, 2'b00, 0, 2'b00, 1, 1, 2, 0, 9, 10, 0);
        tick();
        chk("rd0_dest", {27'd0, rd_o}, 0);
        instr(2'b01, 2'b00, 0, 2'b00, 1, 40, 2, 0, 0, 0, 12);
        memwb(1, 0, 77);
        tick();
        chk("rd0_nofwd", ALUResult_o, 42);
        memwb(0, 0, 0);
        // slt signed, then immediate add
        instr(2'b01, 2'b00, 0, 2'b10, 1, 32'hFFFF_FFFF, 1, 32'h2A, 9, 10, 11);
        tick();
        chk("slt_signed", ALUResult_o, 1);
        instr(2'b01, 2'b00, 1, 2'b00, 1, 8, 32'h55, 32'hFFFF_FFFC, 8, 13, 14);
        tick();
        chk("imm_add", ALUResult_o, 4);
        chk("store_data", writeData_o, 32'h55);

`ifdef MULT_EN
        instr(2'b01, 2'b00, 0, 2'b10, 1, 6, 7, 32'h18, 15, 16, 17);
        run_mul(n);
        chk("mul_stall_cycles", n, 33);
        tick();
        chk("mul_6x7", ALUResult_o, 42);
        chk("mul_rd", {27'd0, rd_o}, 17);
        nop();
        tick();
        instr(2'b01, 2'b00, 0, 2'b10, 1, 32'hFFFF_FFFF, 2, 32'h18, 18, 19, 20);
        run_mul(n);
        chk("mul2_stall_cycles", n, 33);
        tick();
        chk("mul_wrap", ALUResult_o, 32'hFFFF_FFFE);
        nop();
        tick();
        // reset during the multiply
        instr(2'b01, 2'b00, 0, 2'b10, 1, 6, 7, 32'h18, 15, 16, 17);
        #1;
        repeat (10) tick();
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_out", ALUResult_o | {25'd0, WB_o, M_o, 3'd0} | {27'd0, rd_o}, 0);
        chk("mid_rst_stall", {31'd0, stall_o}, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        instr(2'b01, 2'b00, 0, 2'b10, 1, 3, 5, 32'h18, 15, 16, 17);
        run_mul(n);
        chk("mul_after_rst_cycles", n, 33);
        tick();
        chk("mul_after_rst", ALUResult_o, 15);
        nop();
        tick();
`else
        instr(2'b01, 2'b00, 0, 2'b10, 1, 6, 7, 32'h18, 15, 16, 17);
        #1 chk("mul_off_stall", {31'd0, stall_o}, 0);
        tick();
        chk("mul_off_zero", ALUResult_o, 0);
        chk("mul_off_rd", {27'd0, rd_o}, 17);
        nop();
        tick();
`endif

        // Randomized traffic; ID/EX holds while stalled, MEM/WB keeps moving
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) rand_instr();
            memwb(1'($urandom), 5'($urandom_range(0, 7)), rand_val());
            #1;
            hold = stall_o;
            tick();
        end
        nop();
        memwb(0, 0, 0);
        repeat (40) tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
